// File: rtl/apb_cmplr_regbank.sv
`timescale 1ns/1ps
// APB4 completer holding a small register bank: register 0 is a read-only ID,
// the others are byte-strobed read/write. Wait states and error decode are configurable.
module apb_cmplr_regbank #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hDA7A_0001
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);
    localparam int              IDX_W      = ADDR_WIDTH - 2;
    localparam int              SEL_W      = $clog2(NUM_REGS);
    localparam int              STRB_W     = DATA_WIDTH / 8;
    localparam logic [IDX_W:0]  NUM_REGS_V = NUM_REGS[IDX_W:0];
    localparam logic [3:0]      WS_V       = WAIT_STATES[3:0];

    if (DATA_WIDTH != 32) begin : g_chk_data_width
        $error("apb_cmplr_regbank: DATA_WIDTH must be 32");
    end
    if ((NUM_REGS < 2) || (NUM_REGS > (1 << IDX_W))) begin : g_chk_num_regs
        $error("apb_cmplr_regbank: NUM_REGS out of range");
    end
    if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_chk_wait_states
        $error("apb_cmplr_regbank: WAIT_STATES out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP_SEEN, S_WAIT, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_cnt;
    logic [3:0]              w_next_cnt;
    logic                    r_write;
    logic                    r_err;
    logic [IDX_W-1:0]        r_idx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_strb;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic                    r_pready;
    logic                    r_pslverr;
    logic [DATA_WIDTH-1:0]   r_prdata;

    logic                    w_setup;
    logic                    w_take;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_err_in;
    logic [IDX_W-1:0]        w_eff_idx;
    logic                    w_eff_write;
    logic                    w_eff_err;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic                    w_done_next;
    logic                    w_commit;
    logic                    w_unused_addr_lsb;

    assign w_setup           = psel & ~penable;
    assign w_take            = ((r_state == S_IDLE) || (r_state == S_DONE)) && w_setup;
    assign w_idx             = paddr[ADDR_WIDTH-1:2];
    assign w_err_in          = ({1'b0, w_idx} >= NUM_REGS_V) || (pwrite && (w_idx == {IDX_W{1'b0}}));
    assign w_done_next       = (w_next_state == S_DONE);
    assign w_commit          = (r_state == S_DONE) && psel && r_write && !r_err;
    assign w_unused_addr_lsb = &{1'b0, paddr[1:0]};

    assign pready  = r_pready;
    assign prdata  = r_prdata;
    assign pslverr = r_pslverr;

    // Next state and wait counter; DONE is the completion cycle itself.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_setup) begin
                    w_next_cnt   = WS_V;
                    w_next_state = (WS_V == 4'd0) ? S_DONE : S_SETUP_SEEN;
                end else begin
                    w_next_cnt   = 4'd0;
                    w_next_state = S_IDLE;
                end
            end
            S_SETUP_SEEN, S_WAIT: begin
                if (!psel) begin
                    w_next_cnt   = 4'd0;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_cnt   = r_cnt - 4'd1;
                    w_next_state = (r_cnt == 4'd1) ? S_DONE : S_WAIT;
                end
            end
            default: begin
                w_next_cnt   = 4'd0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // With zero wait states the completion is decided in the setup cycle, before the latch.
    always_comb begin
        w_eff_idx   = r_idx;
        w_eff_write = r_write;
        w_eff_err   = r_err;
        if (w_take) begin
            w_eff_idx   = w_idx;
            w_eff_write = pwrite;
            w_eff_err   = w_err_in;
        end else begin
            w_eff_idx   = r_idx;
            w_eff_write = r_write;
            w_eff_err   = r_err;
        end
        if (w_eff_idx == {IDX_W{1'b0}}) begin
            w_rd_word = ID_VALUE;
        end else begin
            w_rd_word = r_regs[w_eff_idx[SEL_W-1:0]];
        end
    end

    // FSM state register and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Setup-phase capture; access-phase changes on the bus are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= {IDX_W{1'b0}};
            r_wdata <= {DATA_WIDTH{1'b0}};
            r_strb  <= {STRB_W{1'b0}};
        end else if (w_take) begin
            r_write <= pwrite;
            r_err   <= w_err_in;
            r_idx   <= w_idx;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
        end
    end

    // Registered response, nonzero only in the completion cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_pready  <= w_done_next;
            r_pslverr <= w_done_next && w_eff_err;
            r_prdata  <= (w_done_next && !w_eff_write && !w_eff_err) ? w_rd_word : {DATA_WIDTH{1'b0}};
        end
    end

    // Register bank; writes commit at the edge that ends the completion cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (w_commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (r_strb[b]) begin
                    r_regs[r_idx[SEL_W-1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_cmplr_regbank.sv
`timescale 1ns/1ps
// Bench for apb_cmplr_regbank: one instance with no wait states and one with three,
// driven with directed and random APB transfers against a register-array model.
module tb_apb_cmplr_regbank;
    localparam logic [31:0] ID = 32'hDA7A_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [7:0]  paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mdl [2][16];

    always #5 clk = ~clk;

    apb_cmplr_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0), .ID_VALUE(ID)) u_dut_ws0 (
        .clk(clk), .reset(reset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

    apb_cmplr_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(3), .ID_VALUE(ID)) u_dut_ws3 (
        .clk(clk), .reset(reset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                mdl[d][i] = 32'h0;
            end
        end
    endtask

    task automatic bus_idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        pwrite[d]  = 1'b0;
        paddr[d]   = 8'h00;
        pwdata[d]  = 32'h0;
        pstrb[d]   = 4'h0;
    endtask

    task automatic idle_cycle(input int d);
        @(posedge clk); #1;
        bus_idle(d);
        @(negedge clk);
        check_eq($sformatf("d%0d_idle_pready", d), {31'h0, pready[d]}, 32'h0);
        check_eq($sformatf("d%0d_idle_prdata", d), prdata[d], 32'h0);
    endtask

    task automatic check_quiet(input int d, input string tag);
        check_eq($sformatf("d%0d_%s_pready", d, tag), {31'h0, pready[d]}, 32'h0);
        check_eq($sformatf("d%0d_%s_pslverr", d, tag), {31'h0, pslverr[d]}, 32'h0);
        check_eq($sformatf("d%0d_%s_prdata", d, tag), prdata[d], 32'h0);
    endtask

    // Full transfer; returns at the falling edge inside the completion cycle with psel still high.
    task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit wiggle);
        int          idx;
        bit          err;
        int          n;
        logic [31:0] exp_rd;
        idx    = int'(addr[7:2]);
        err    = (idx >= 16) || (wr && (idx == 0));
        n      = ws_of(d) + 1;
        exp_rd = (wr || err) ? 32'h0 : ((idx == 0) ? ID : mdl[d][idx]);
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
        @(negedge clk);
        check_quiet(d, "setup");
        @(posedge clk); #1;
        penable[d] = 1'b1;
        if (wiggle) begin
            paddr[d]  = 8'($urandom_range(0, 255));
            pwdata[d] = $urandom;
            pstrb[d]  = 4'($urandom_range(0, 15));
        end
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            if (k < n) begin
                check_quiet(d, $sformatf("a%02h_wait%0d", addr, k));
            end else begin
                check_eq($sformatf("d%0d_a%02h_pready", d, addr), {31'h0, pready[d]}, 32'h1);
                check_eq($sformatf("d%0d_a%02h_pslverr", d, addr), {31'h0, pslverr[d]}, {31'h0, err});
                check_eq($sformatf("d%0d_a%02h_prdata", d, addr), prdata[d], exp_rd);
            end
        end
        if (wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mdl[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus_idle(0);
        bus_idle(1);
        reset_model();
        repeat (3) @(negedge clk);
        check_quiet(0, "reset");
        check_quiet(1, "reset");
        reset = 1'b0;

        // Directed, no wait states
        xfer(0, 1'b1, 8'h04, 32'h1234_5678, 4'hF, 1'b0);
        idle_cycle(0);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0);
        xfer(0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, 1'b0);
        xfer(0, 1'b1, 8'h04, 32'h0000_00AA, 4'b0001, 1'b0);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0);
        xfer(0, 1'b1, 8'h04, 32'h5555_5555, 4'h0, 1'b0);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b1);
        xfer(0, 1'b1, 8'h40, 32'hABCD_EF01, 4'hF, 1'b0);
        xfer(0, 1'b1, 8'h00, 32'hABCD_EF01, 4'hF, 1'b0);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
        xfer(0, 1'b0, 8'h44, 32'h0, 4'h0, 1'b0);
        idle_cycle(0);

        // penable without a setup phase is ignored
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 8'h04; pwdata[0] = 32'hDEAD_BEEF; pstrb[0] = 4'hF;
        repeat (3) begin
            @(negedge clk);
            check_quiet(0, "penable_only");
        end
        idle_cycle(0);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 1'b0);
        idle_cycle(0);

        // Wait states
        xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
        xfer(1, 1'b1, 8'h14, 32'h1111_2222, 4'hF, 1'b0);
        idle_cycle(1);

        // Abort by psel drop in the 2nd access cycle
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'h14; pwdata[1] = 32'hBAD0_BAD0; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(negedge clk);
        check_quiet(1, "abort_a1");
        @(posedge clk); #1;
        bus_idle(1);
        repeat (5) begin
            @(negedge clk);
            check_quiet(1, "abort_after");
        end
        xfer(1, 1'b0, 8'h14, 32'h0, 4'h0, 1'b0);
        idle_cycle(1);

        // Reset during WAIT of a write to 8'h08
        xfer(1, 1'b1, 8'h08, 32'h7777_8888, 4'hF, 1'b0);
        idle_cycle(1);
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'h08; pwdata[1] = 32'hCAFE_F00D; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_quiet(1, "rst_wait");
        bus_idle(1);
        reset_model();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0);
        idle_cycle(1);

        // Reset during a completion cycle with nonzero read data
        xfer(0, 1'b1, 8'h0C, 32'h5A5A_1234, 4'hF, 1'b0);
        xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_quiet(0, "rst_done");
        bus_idle(0);
        reset_model();
        @(negedge clk);
        reset = 1'b0;
        xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0);
        idle_cycle(0);

        // Random traffic, back-to-back or with idle gaps
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 80; t++) begin
                xfer(d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 79)), $urandom,
                     4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 1) == 1) idle_cycle(d);
            end
            idle_cycle(d);
            for (int i = 1; i < 16; i++) begin
                xfer(d, 1'b0, 8'(i * 4), 32'h0, 4'h0, 1'b0);
            end
            idle_cycle(d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_cmplr_regbank.md
Name: apb_cmplr_regbank

Overview:
- Synthesizable APB4 completer (slave) holding a small register bank, with parameterized wait states and error response.
- Acts as the responder end of the APB link that the self-test environment drives from its master agent.
- Used as the reference DUT for the APB self-test bench; it replaces the slave agent on the completer side.

Parameters:
- ADDR_WIDTH, 8, paddr width; word index = paddr[ADDR_WIDTH-1:2].
- DATA_WIDTH, 32, pwdata/prdata width; 32 only, other values are a compile-time error.
- NUM_REGS, 16, number of 32-bit registers; legal range 2..2**(ADDR_WIDTH-2).
- WAIT_STATES, 0, access cycles with pready=0 before completion; range 0..15.
- ID_VALUE, 32'hDA7A_0001, read-only contents of register 0.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- psel  in  1  completer select.
- penable  in  1  access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte write strobes.
- pready  out  1  transfer complete, registered.
- prdata  out  DATA_WIDTH  read data, registered.
- pslverr  out  1  error response, registered.

Behaviour:
- Reset (async assert, sync release):
  - pready=0, prdata=0, pslverr=0, FSM=IDLE, wait counter=0.
  - Registers 1..NUM_REGS-1 = 0.
- FSM states: IDLE, SETUP_SEEN, WAIT, DONE.
  - IDLE: psel=1, penable=0 -> SETUP_SEEN. Latch paddr/pwrite/pwdata/pstrb. Load counter=WAIT_STATES.
  - SETUP_SEEN (first access cycle): counter==0 -> DONE, otherwise -> WAIT with counter decremented.
  - WAIT: decrement each cycle; at 0 -> DONE.
  - DONE: pready=1 for exactly one cycle. Next state is IDLE; if that same cycle shows a new setup (psel=1, penable=0), go directly to SETUP_SEEN.
- Transfer latency:
  - Completion is the Nth access cycle, N = WAIT_STATES+1.
  - pready is high only in that cycle.
  - With WAIT_STATES=0, pready is high in the first access cycle (two-cycle transfer).
- Error decode: index >= NUM_REGS, or a write to index 0.
  - Completion has pslverr=1 and prdata=0.
  - No register changes.
- Reads: prdata = reg[index] during the completion cycle, 0 in all other cycles.
- Writes:
  - Commit at the rising edge ending the completion cycle.
  - Byte lane b is updated iff pstrb[b]=1.
  - pstrb=0 is a legal no-op write with pslverr=0.
- pslverr is valid only with pready=1 and is 0 otherwise.
- Protocol deviations:
  - penable=1 seen while IDLE: ignored; stay IDLE, pready=0.
  - psel dropping before completion: abort to IDLE, no write, no pready.
  - Address/control changing during the access phase: ignored; the latched setup values are used.
- Reset asserted mid-transfer: the transfer is aborted, all outputs go to 0 immediately, and no partial write occurs.
- Back-to-back transfers: one setup cycle is required after each completion (APB4 rule); there is no idle gap requirement.

Test Plan:
- Write/read, WAIT_STATES=0:
  - Write 32'h1234_5678 to paddr 8'h04 with pstrb=4'hF -> pready high in the 1st access cycle, pslverr=0.
  - Read 8'h04 -> prdata=32'h1234_5678.
- Byte strobes:
  - Preload reg1=32'hFFFF_FFFF, then write 32'h0000_00AA with pstrb=4'b0001 -> read returns 32'hFFFF_FFAA.
- Wait states, WAIT_STATES=3:
  - Read of paddr 8'h00 -> pready=0 for 3 access cycles, then 1 for one cycle with prdata=32'hDA7A_0001.
- Errors, NUM_REGS=16:
  - Write to paddr 8'h40 -> pslverr=1 with pready.
  - Write to paddr 8'h00 -> pslverr=1.
  - Read back 8'h00 -> still ID_VALUE.
- Abort:
  - Deassert psel in the 2nd access cycle of a write with WAIT_STATES=3 -> no pready; the target register keeps its old value.
- Reset mid-transfer:
  - Assert reset during WAIT of a write to 8'h08 -> outputs 0 at once, reg2=0 after release.
  - A following read of 8'h08 completes normally with 0.
